// File: rtl/c16_snd.sv
// ---------------------------------------------------------------------------
// c16_snd : four-voice square-wave sound generator fed by the c16 core.
//
// The core programs each voice through a one-cycle register-write strobe.
// A free-running divider produces sample ticks. On every tick each enabled
// voice advances its half-period counter, and a five-step sequential mixer
// sums the voices into a signed 16-bit PCM sample.
//
// Ports
//   clk           in   system clock, all logic on posedge
//   resetn        in   asynchronous, active-low reset
//   snd_wen       in   one-cycle register write strobe
//   w_param[1:0]  in   0 period, 1 volume, 2 duration, 3 control
//   w_index[10:0] in   [1:0] voice; [10:2] must be zero or the write is dropped
//   w_val[15:0]   in   write data
//   sample[15:0]  out  signed mixed PCM sample
//   sample_valid  out  one-cycle pulse when sample updates
//   active[3:0]   out  per-voice enable bits (registered en)
//   dbg_state[2:0] out mixer FSM state, for observation only
//
// Handshakes: there is no ready/backpressure anywhere. A write is taken on
// every cycle snd_wen is high; sample_valid is a single-cycle pulse that the
// consumer must capture when it sees it.
//
// Configuration
//   C16_SND_NOISE_EN  when defined, voice 3 is a noise voice driven by a
//                     15-bit LFSR (x^15 + x^14 + 1, seed 15'h7FFF); when
//                     undefined voice 3 is an ordinary square voice.
// ---------------------------------------------------------------------------
module c16_snd #(
  parameter int unsigned CLK_DIV = 1134
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        snd_wen,
  input  logic [1:0]  w_param,
  input  logic [10:0] w_index,
  input  logic [15:0] w_val,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic [3:0]  active,
  output logic [2:0]  dbg_state
);

  localparam int NV = 4;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  localparam logic [1:0] P_PERIOD = 2'd0;
  localparam logic [1:0] P_VOL    = 2'd1;
  localparam logic [1:0] P_DUR    = 2'd2;
  localparam logic [1:0] P_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MIX0 = 3'd1,
    ST_MIX1 = 3'd2,
    ST_MIX2 = 3'd3,
    ST_MIX3 = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Sample-tick divider
  // -------------------------------------------------------------------------
  logic [15:0] div_q, div_d;
  logic        tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? 16'd0 : div_q + 16'd1;
  end

  // -------------------------------------------------------------------------
  // Voice registers
  // -------------------------------------------------------------------------
  logic [NV-1:0][15:0] period_q, period_d;
  logic [NV-1:0][7:0]  vol_q,    vol_d;
  logic [NV-1:0][15:0] dur_q,    dur_d;
  logic [NV-1:0][15:0] cnt_q,    cnt_d;
  logic [NV-1:0]       en_q,     en_d;
  logic [NV-1:0]       level_q,  level_d;
  logic [NV-1:0]       mask_q,   mask_d;

`ifdef C16_SND_NOISE_EN
  logic [14:0] lfsr_q, lfsr_d;
  logic [14:0] lfsr_step;

  // Fibonacci form: taps at bits 14 and 13 feed the new bit 0.
  assign lfsr_step = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
`endif

  logic                wr_hit;
  logic [1:0]          wr_voice;
  logic [NV-1:0]       wr_sel;
  logic [NV-1:0][15:0] period_eff;

  assign wr_hit   = snd_wen && (w_index[10:2] == 9'd0);
  assign wr_voice = w_index[1:0];

  always_comb begin
    period_d = period_q;
    vol_d    = vol_q;
    dur_d    = dur_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    level_d  = level_q;
    mask_d   = mask_q;
`ifdef C16_SND_NOISE_EN
    lfsr_d   = lfsr_q;
`endif

    for (int i = 0; i < NV; i++) begin
      wr_sel[i] = wr_hit && (wr_voice == 2'(i));
      // A period written on the tick cycle is the one the compare uses.
      period_eff[i] = (wr_sel[i] && (w_param == P_PERIOD)) ? w_val : period_q[i];
    end

    if (tick) begin
      // mask captures en before any expiry so a voice with duration N is
      // heard for exactly N samples.
      mask_d = en_q;
      for (int i = 0; i < NV; i++) begin
        if (en_q[i] && (period_eff[i] != 16'd0)) begin
          // >= (not ==) so that shrinking period below cnt toggles at once.
          if (cnt_q[i] >= period_eff[i] - 16'd1) begin
            cnt_d[i] = 16'd0;
`ifdef C16_SND_NOISE_EN
            if (i == NV - 1) begin
              lfsr_d     = lfsr_step;
              level_d[i] = lfsr_step[0];
            end else begin
              level_d[i] = ~level_q[i];
            end
`else
            level_d[i] = ~level_q[i];
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        // A duration write in the same cycle replaces the countdown.
        if (en_q[i] && (dur_q[i] != 16'd0) && !(wr_sel[i] && (w_param == P_DUR))) begin
          dur_d[i] = dur_q[i] - 16'd1;
          if (dur_q[i] == 16'd1) begin
            en_d[i] = 1'b0;
          end
        end
      end
    end

    // Writes are applied last so they win over the tick for their field.
    if (wr_hit) begin
      case (w_param)
        P_PERIOD: period_d[wr_voice] = w_val;
        P_VOL:    vol_d[wr_voice]    = w_val[7:0];
        P_DUR:    dur_d[wr_voice]    = w_val;
        P_CTRL: begin
          en_d[wr_voice] = w_val[0];
          if (w_val[1]) begin
            cnt_d[wr_voice]   = 16'd0;
            level_d[wr_voice] = 1'b1;
`ifdef C16_SND_NOISE_EN
            if (wr_voice == 2'(NV - 1)) begin
              lfsr_d = 15'h7FFF;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Mixer FSM
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [10:0] acc_q, acc_d;
  logic [15:0] sample_q, sample_d;
  logic        valid_q, valid_d;
  logic [1:0]  mix_sel;
  logic [10:0] vol_ext;
  logic [10:0] mix_term;

  always_comb begin
    case (state_q)
      ST_MIX1: mix_sel = 2'd1;
      ST_MIX2: mix_sel = 2'd2;
      ST_MIX3: mix_sel = 2'd3;
      default: mix_sel = 2'd0;
    endcase
    vol_ext = {3'b000, vol_q[mix_sel]};
    if (!mask_q[mix_sel]) begin
      mix_term = 11'd0;
    end else if (level_q[mix_sel]) begin
      mix_term = vol_ext;
    end else begin
      mix_term = -vol_ext;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_MIX0;
          acc_d   = 11'd0;
        end
      end
      ST_MIX0: begin
        acc_d   = acc_q + mix_term;
        state_d = ST_MIX1;
      end
      ST_MIX1: begin
        acc_d   = acc_q + mix_term;
        state_d = ST_MIX2;
      end
      ST_MIX2: begin
        acc_d   = acc_q + mix_term;
        state_d = ST_MIX3;
      end
      ST_MIX3: begin
        acc_d    = acc_q + mix_term;
        state_d  = ST_OUT;
        // Sign-extend-then-shift-by-5 of an 11-bit value is exactly the
        // 11 bits followed by five zeros.
        sample_d = {acc_d, 5'b00000};
        valid_d  = 1'b1;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q    <= '0;
      period_q <= '0;
      vol_q    <= '0;
      dur_q    <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      level_q  <= '0;
      mask_q   <= '0;
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      period_q <= period_d;
      vol_q    <= vol_d;
      dur_q    <= dur_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      level_q  <= level_d;
      mask_q   <= mask_d;
      state_q  <= state_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

`ifdef C16_SND_NOISE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 15'h7FFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign active       = en_q;
  assign dbg_state    = state_q;

endmodule
